// File: rtl/conv_pkg.sv
// conv_pkg: size decoding shared by the feature-map streamer and the
// convolution control unit.
//
// Contents:
//   CONV_LANES, CONV_PIXEL_WIDTH  pixels per beat and bits per pixel
//   cfg_reserved()                true for reserved size encodings
//   image_size()                  IMAGE_SIZE_choose -> square edge in pixels
//   channel_size()                CHANNEL_SIZE_choose -> channel count
//   plane_beats_log2()            log2 of beats in one channel plane
//   total_beats_log2()            log2 of beats in a whole feature map
//
// Every legal size is a power of two, so beat counts are carried as
// log2 values and turned into masks/limits with shifts (no multipliers).
package conv_pkg;

  localparam int unsigned CONV_LANES       = 16;
  localparam int unsigned CONV_PIXEL_WIDTH = 16;

  // Image encodings 6/7 and channel encoding 3 are reserved.
  function automatic logic cfg_reserved(input logic [2:0] img, input logic [1:0] ch);
    return (img > 3'd5) || (ch == 2'd3);
  endfunction

  // 0=4 .. 5=128 pixels; reserved codes decode to 0.
  function automatic logic [7:0] image_size(input logic [2:0] img);
    return (img > 3'd5) ? 8'd0 : (8'd4 << img);
  endfunction

  // 0=256, 1=128, 2=64 channels; reserved code decodes to 0.
  function automatic logic [8:0] channel_size(input logic [1:0] ch);
    return (ch == 2'd3) ? 9'd0 : (9'd256 >> ch);
  endfunction

  // Plane beats = W * max(1, W/16). For W <= 16 that is W (log2 = img+2);
  // above 16 it is W*W/16 (log2 = 2*(img+2) - 4 = 2*img).
  function automatic logic [3:0] plane_beats_log2(input logic [2:0] img);
    return (img <= 3'd2) ? ({1'b0, img} + 4'd2) : {img, 1'b0};
  endfunction

  // Total beats = plane beats * channels; channels = 2^(8-ch).
  function automatic logic [4:0] total_beats_log2(input logic [2:0] img, input logic [1:0] ch);
    return {1'b0, plane_beats_log2(img)} + (5'd8 - {3'b000, ch});
  endfunction

endpackage

// File: rtl/fm_stream_skid_fifo.sv
// fm_stream_skid_fifo: two-entry output buffer holding stream beats
// (data + tlast) between the BRAM read port and the AXI-stream output.
//
// Ports:
//   clk, aresetn        clock, asynchronous active-low reset
//   wr_en, wr_data,     push one beat (caller guarantees not full)
//   wr_last
//   rd_en               pop the head beat (caller guarantees not empty)
//   rd_data, rd_last    head beat; all-zero after reset
//   full, empty         occupancy flags
module fm_stream_skid_fifo #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_last,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last,
  output logic             full,
  output logic             empty
);

  logic [WIDTH:0] mem_q [2];
  logic           wr_ptr_q;
  logic           rd_ptr_q;
  logic [1:0]     count_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {wr_last, wr_data};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (rd_en) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign {rd_last, rd_data} = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/fm_stream_master.sv
// fm_stream_master: streams one feature map from BRAM to the convolution
// input as an AXI-stream, one LANES-pixel beat per BRAM word.
//
// Ports:
//   clk, aresetn          clock, asynchronous active-low reset
//   start                 one-cycle request; size inputs latched when accepted
//   IMAGE_SIZE_choose     0..5 -> 4..128 pixels square (6,7 reserved)
//   CHANNEL_SIZE_choose   0..2 -> 256/128/64 channels (3 reserved)
//   bram_en, bram_addr    BRAM read request; data returns one cycle later
//   bram_dout             BRAM read data
//   m_axis_t*             output stream (tdata, tvalid, tready, tlast)
//   busy                  high from the cycle after start until done
//   done                  one-cycle pulse after the final beat is accepted
//   cfg_err               one-cycle pulse for start with a reserved encoding
//   stall_cnt             (FM_STREAM_STALL_CNT_EN only) tvalid&&!tready cycles
//   state_dbg             current FSM state (IDLE=0, RUN=1, DRAIN=2)
//
// Optional build macro: FM_STREAM_STALL_CNT_EN adds the stall_cnt port.
//
// Handshake: a beat moves when m_axis_tvalid && m_axis_tready in the same
// cycle; once tvalid is raised, tdata/tlast stay constant and tvalid stays
// high until that handshake happens.
//
// Datapath: the BRAM word arriving this cycle (pending_q) goes straight to
// the output when the buffer is empty, otherwise into the 2-entry buffer.
// A read is launched only if, after this cycle's pop, buffer + in-flight
// read leaves room, so backpressure never overflows the buffer while a
// steady tready=1 still gives one beat per cycle.
module fm_stream_master
  import conv_pkg::*;
#(
  parameter int PIXEL_WIDTH = CONV_PIXEL_WIDTH,
  parameter int LANES       = CONV_LANES,
  parameter int ADDR_WIDTH  = 18
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         start,
  input  logic [2:0]                   IMAGE_SIZE_choose,
  input  logic [1:0]                   CHANNEL_SIZE_choose,
  output logic                         bram_en,
  output logic [ADDR_WIDTH-1:0]        bram_addr,
  input  logic [LANES*PIXEL_WIDTH-1:0] bram_dout,
  output logic [LANES*PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
`ifdef FM_STREAM_STALL_CNT_EN
  output logic [31:0]                  stall_cnt,
`endif
  output logic [1:0]                   state_dbg
);

  localparam int DW      = LANES * PIXEL_WIDTH;
  localparam int PLANE_W = 11; // up to 1024 beats per plane

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH:0] ONE_A  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PLANE_W:0]    ONE_P  = {{PLANE_W{1'b0}}, 1'b1};

  logic [1:0]            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic [PLANE_W-1:0]    plane_cnt_q;
  logic [PLANE_W-1:0]    plane_last_q;
  logic [LANES-1:0]      lane_keep_q;
  logic                  pending_q;
  logic                  pending_last_q;

  // Latched-config candidates, computed from the live inputs.
  logic [ADDR_WIDTH:0]   total_span;
  logic [PLANE_W:0]      plane_span;
  logic [LANES-1:0]      lane_keep_d;

  logic                  start_ok;
  logic                  beat_valid;
  logic                  pop;
  logic                  bypass;
  logic                  plane_end;
  logic                  last_issue;
  logic                  final_beat;
  logic [2:0]            occ_after;
  logic [1:0]            fifo_count;
  logic [DW-1:0]         masked_dout;

  logic                  fifo_wr;
  logic                  fifo_rd;
  logic [DW-1:0]         fifo_data;
  logic                  fifo_last;
  logic                  fifo_full;
  logic                  fifo_empty;

  // ---------------- config decode ----------------
  always_comb begin
    total_span = ONE_A << total_beats_log2(IMAGE_SIZE_choose, CHANNEL_SIZE_choose);
    plane_span = ONE_P << plane_beats_log2(IMAGE_SIZE_choose);
    lane_keep_d = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_keep_d[i] = (i < int'(image_size(IMAGE_SIZE_choose)));
    end
  end

  assign start_ok = start && (state_q == ST_IDLE) &&
                    !cfg_reserved(IMAGE_SIZE_choose, CHANNEL_SIZE_choose);

  // ---------------- output selection ----------------
  // Narrow images (W < LANES) leave the upper lanes of the BRAM word unused;
  // those lanes are zeroed before the beat enters the stream.
  always_comb begin
    masked_dout = '0;
    for (int i = 0; i < LANES; i++) begin
      masked_dout[i*PIXEL_WIDTH +: PIXEL_WIDTH] =
        lane_keep_q[i] ? bram_dout[i*PIXEL_WIDTH +: PIXEL_WIDTH] : '0;
    end
  end

  assign fifo_count = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign beat_valid = !fifo_empty || pending_q;
  assign pop        = beat_valid && m_axis_tready;
  assign bypass     = fifo_empty && pending_q;

  assign m_axis_tvalid = beat_valid;
  assign m_axis_tdata  = bypass ? masked_dout : fifo_data;
  assign m_axis_tlast  = bypass ? pending_last_q : (fifo_last && !fifo_empty);

  // An arriving word is buffered unless it leaves the block this very cycle.
  assign fifo_wr = pending_q && !(bypass && pop);
  assign fifo_rd = pop && !fifo_empty;

  // ---------------- read issue ----------------
  assign occ_after  = {1'b0, fifo_count} + {2'b00, pending_q} - {2'b00, pop};
  assign bram_en    = (state_q == ST_RUN) && (occ_after < 3'd2);
  assign bram_addr  = addr_q;
  assign plane_end  = (plane_cnt_q == plane_last_q);
  assign last_issue = bram_en && (addr_q == last_addr_q);

  // The last beat leaves once nothing else remains buffered or in flight.
  assign final_beat = (state_q == ST_DRAIN) && pop &&
                      (({1'b0, fifo_count} + {2'b00, pending_q}) == 3'd1);

  // ---------------- state and counters ----------------
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      last_addr_q    <= '0;
      plane_cnt_q    <= '0;
      plane_last_q   <= '0;
      lane_keep_q    <= '0;
      pending_q      <= 1'b0;
      pending_last_q <= 1'b0;
      done           <= 1'b0;
      cfg_err        <= 1'b0;
    end else begin
      done    <= final_beat;
      cfg_err <= start && (state_q == ST_IDLE) &&
                 cfg_reserved(IMAGE_SIZE_choose, CHANNEL_SIZE_choose);

      pending_q      <= bram_en;
      pending_last_q <= bram_en && plane_end;

      case (state_q)
        ST_IDLE:  if (start_ok)   state_q <= ST_RUN;
        ST_RUN:   if (last_issue) state_q <= ST_DRAIN;
        ST_DRAIN: if (final_beat) state_q <= ST_IDLE;
        default:                  state_q <= ST_IDLE;
      endcase

      if (start_ok) begin
        last_addr_q  <= ADDR_WIDTH'(total_span - ONE_A);
        plane_last_q <= PLANE_W'(plane_span - ONE_P);
        lane_keep_q  <= lane_keep_d;
        addr_q       <= '0;
        plane_cnt_q  <= '0;
      end else if (bram_en) begin
        // The address parks on the final value until the next start.
        if (!last_issue) addr_q <= addr_q + 1'b1;
        plane_cnt_q <= plane_end ? '0 : plane_cnt_q + 1'b1;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

`ifdef FM_STREAM_STALL_CNT_EN
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (m_axis_tvalid && !m_axis_tready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  fm_stream_skid_fifo #(
    .WIDTH (DW)
  ) u_skid (
    .clk     (clk),
    .aresetn (aresetn),
    .wr_en   (fifo_wr),
    .wr_data (masked_dout),
    .wr_last (pending_last_q),
    .rd_en   (fifo_rd),
    .rd_data (fifo_data),
    .rd_last (fifo_last),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_fm_stream_master.sv
// Testbench for fm_stream_master: BRAM model, tready driver, scoreboard
// with expected-beat queue, directed scenarios, final report.
module tb_fm_stream_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         aresetn;
  logic         start;
  logic [2:0]   img_sel;
  logic [1:0]   ch_sel;
  logic         bram_en;
  logic [17:0]  bram_addr;
  logic [255:0] bram_dout;
  logic [255:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         busy;
  logic         done;
  logic         cfg_err;
  logic [1:0]   state_dbg;
`ifdef FM_STREAM_STALL_CNT_EN
  logic [31:0]  stall_cnt;
`endif

  fm_stream_master dut (
    .clk                 (clk),
    .aresetn             (aresetn),
    .start               (start),
    .IMAGE_SIZE_choose   (img_sel),
    .CHANNEL_SIZE_choose (ch_sel),
    .bram_en             (bram_en),
    .bram_addr           (bram_addr),
    .bram_dout           (bram_dout),
    .m_axis_tdata        (tdata),
    .m_axis_tvalid       (tvalid),
    .m_axis_tready       (tready),
    .m_axis_tlast        (tlast),
    .busy                (busy),
    .done                (done),
    .cfg_err             (cfg_err),
`ifdef FM_STREAM_STALL_CNT_EN
    .stall_cnt           (stall_cnt),
`endif
    .state_dbg           (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_errors = 0;
  logic [256:0] exp_q[$];
  logic [17:0]  exp_addr = '0;
  bit           addr_chk_en = 1'b0;
  int           beats_seen = 0;
  int           en_count = 0;
  int           ready_mode = 0;   // 0: always ready, 1: ready ~30% of cycles
  int           stall_left = 0;   // forced not-ready cycles pending
  int           cur_total = 0;

  task automatic check(input string name, input logic [256:0] act, input logic [256:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // BRAM contents: lane i of word a holds {i, a[11:0]}.
  function automatic logic [255:0] mem_word(input logic [17:0] a);
    logic [255:0] w;
    logic [3:0]   ln;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      ln = 4'(i);
      w[16*i +: 16] = {ln, a[11:0]};
    end
    return w;
  endfunction

  function automatic logic [255:0] exp_word(input logic [17:0] a, input int w);
    logic [255:0] d;
    d = mem_word(a);
    for (int i = 0; i < 16; i++) begin
      if (i >= w) d[16*i +: 16] = 16'h0000;
    end
    return d;
  endfunction

  // ---------------- BRAM model (one-cycle read latency) ----------------
  initial begin
    logic [17:0] a;
    bit          rd;
    bram_dout = '0;
    forever begin
      @(posedge clk);
      rd = bram_en;
      a  = bram_addr;
      #1;
      if (rd) bram_dout = mem_word(a);
    end
  end

  // ---------------- tready driver ----------------
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        tready = 1'b0;
        stall_left--;
      end else if (ready_mode == 1) begin
        tready = ($urandom_range(0, 99) < 30);
      end else begin
        tready = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit           have_hold;
    logic [256:0] held;
    have_hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (aresetn) begin
        if (have_hold) begin
          check("hold_tvalid", 257'(tvalid), 257'(1));
          check("hold_beat", {tlast, tdata}, held);
        end
        have_hold = 1'b0;
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL extra_beat: got %h with no beat expected", {tlast, tdata});
          end else begin
            check("beat", {tlast, tdata}, exp_q.pop_front());
          end
          beats_seen++;
        end else if (tvalid) begin
          have_hold = 1'b1;
          held = {tlast, tdata};
        end
        if (bram_en) begin
          en_count++;
          if (addr_chk_en) begin
            check("bram_addr", 257'(bram_addr), 257'(exp_addr));
            exp_addr++;
          end
        end
      end else begin
        have_hold = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [2:0] ic, input logic [1:0] cc);
    @(posedge clk);
    #1;
    img_sel = ic;
    ch_sel  = cc;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic begin_run(input int ic, input int cc, input int mode, input bit chk_lat);
    int w, bpr, ch, plane;
    w     = 4 << ic;
    bpr   = (w < 16) ? 1 : w / 16;
    ch    = 256 >> cc;
    plane = w * bpr;
    cur_total = ch * plane;
    for (int a = 0; a < cur_total; a++) begin
      exp_q.push_back({((a % plane) == plane - 1) ? 1'b1 : 1'b0, exp_word(18'(a), w)});
    end
    exp_addr    = '0;
    addr_chk_en = 1'b1;
    beats_seen  = 0;
    ready_mode  = mode;
    pulse_start(3'(ic), 2'(cc));
    if (chk_lat) begin
      @(negedge clk);
      check("lat_bram_en_c1", 257'(bram_en), 257'(1));
      check("lat_tvalid_c1", 257'(tvalid), 257'(0));
      check("lat_busy_c1", 257'(busy), 257'(1));
      @(negedge clk);
      check("lat_tvalid_c2", 257'(tvalid), 257'(1));
    end
  endtask

  task automatic finish_run(input string tag);
    bit got;
    got = 1'b0;
    for (int c = 0; c < cur_total * 12 + 200; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_done_timeout: no done within budget, beats=%0d of %0d", tag, beats_seen, cur_total);
    end else begin
      check({tag, "_busy_at_done"}, 257'(busy), 257'(0));
      check({tag, "_queue_empty"}, 257'(exp_q.size()), 257'(0));
      check({tag, "_beat_count"}, 257'(beats_seen), 257'(cur_total));
      check({tag, "_addr_parked"}, 257'(bram_addr), 257'(cur_total - 1));
      @(negedge clk);
      check({tag, "_done_pulse"}, 257'(done), 257'(0));
    end
    addr_chk_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_beats(input int n);
    for (int c = 0; c < n * 12 + 100; c++) begin
      @(negedge clk);
      if (beats_seen >= n) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_beats_timeout: beats=%0d wanted %0d", beats_seen, n);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_bram_en"}, 257'(bram_en), 257'(0));
    check({tag, "_bram_addr"}, 257'(bram_addr), 257'(0));
    check({tag, "_tvalid"}, 257'(tvalid), 257'(0));
    check({tag, "_tlast"}, 257'(tlast), 257'(0));
    check({tag, "_tdata"}, 257'(tdata), 257'(0));
    check({tag, "_busy"}, 257'(busy), 257'(0));
    check({tag, "_done"}, 257'(done), 257'(0));
    check({tag, "_cfg_err"}, 257'(cfg_err), 257'(0));
    check({tag, "_state"}, 257'(state_dbg), 257'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int en_before;
    aresetn = 1'b0;
    start   = 1'b0;
    img_sel = 3'd0;
    ch_sel  = 2'd0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    repeat (2) @(negedge clk);

    // W=4, C=64: 256 beats, tlast every 4th, upper 12 lanes zero, latency 1/2.
    begin_run(0, 2, 0, 1'b1);
    finish_run("w4c64");

    // Reserved encodings: cfg_err pulse, no transfer.
    en_before = en_count;
    pulse_start(3'd6, 2'd0);
    @(negedge clk);
    check("cfgerr_img_pulse", 257'(cfg_err), 257'(1));
    check("cfgerr_img_busy", 257'(busy), 257'(0));
    @(negedge clk);
    check("cfgerr_img_clear", 257'(cfg_err), 257'(0));
    pulse_start(3'd1, 2'd3);
    @(negedge clk);
    check("cfgerr_ch_pulse", 257'(cfg_err), 257'(1));
    repeat (5) @(negedge clk);
    check("cfgerr_busy_after", 257'(busy), 257'(0));
    check("cfgerr_no_reads", 257'(en_count - en_before), 257'(0));

    // W=16, C=64 with ~30% tready: exact sequence, stable during stalls.
    begin_run(2, 2, 1, 1'b0);
    finish_run("w16c64_rand");

    // W=8, C=128: size inputs change and a second start arrive mid-run.
    begin_run(1, 1, 0, 1'b1);
    repeat (20) @(negedge clk);
    pulse_start(3'd5, 2'd0);
    img_sel = 3'd3;
    ch_sel  = 2'd2;
    finish_run("w8c128_ignore");

    // W=64, C=64: long back-to-back run, tlast every 256 beats.
    begin_run(4, 2, 0, 1'b0);
    finish_run("w64c64");

    // Reset in the middle of a W=32 run, then a fresh run from address 0.
    begin_run(3, 2, 0, 1'b0);
    wait_beats(100);
    @(posedge clk);
    #1;
    aresetn = 1'b0;
    addr_chk_en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_quiet("midreset");
    @(negedge clk);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_busy", 257'(busy), 257'(0));
    check("post_reset_bram_en", 257'(bram_en), 257'(0));
    begin_run(1, 0, 0, 1'b1);
    finish_run("w8c256_after_reset");

`ifdef FM_STREAM_STALL_CNT_EN
    // Exactly seven not-ready cycles mid-run.
    begin_run(2, 1, 0, 1'b0);
    wait_beats(500);
    stall_left = 7;
    finish_run("stall7");
    check("stall_cnt", 257'(stall_cnt), 257'(7));
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fm_stream_master.md
FM_STREAM_MASTER -- requirements
Module: fm_stream_master

Interface
REQ-001 Parameters (name, default, meaning): PIXEL_WIDTH, 16, bits per pixel; LANES, 16, pixels per beat; ADDR_WIDTH, 18, BRAM beat-address width.
REQ-002 Ports (name direction width meaning), one per line:
  clk  input  1  sole clock, rising edge
  aresetn  input  1  asynchronous active-low reset
  start  input  1  one-cycle request to stream one feature map
  IMAGE_SIZE_choose  input  3  0=4,1=8,2=16,3=32,4=64,5=128 pixels square; 6,7 reserved
  CHANNEL_SIZE_choose  input  2  0=256,1=128,2=64 channels; 3 reserved
  bram_en  output  1  feature-map BRAM read enable
  bram_addr  output  ADDR_WIDTH  linear beat address
  bram_dout  input  LANES*PIXEL_WIDTH  read data, valid exactly one cycle after bram_en
  m_axis_tdata  output  LANES*PIXEL_WIDTH  stream data to convolution input
  m_axis_tvalid  output  1  beat valid
  m_axis_tready  input  1  consumer ready
  m_axis_tlast  output  1  last beat of a channel plane
  busy  output  1  transfer in progress
  done  output  1  one-cycle pulse after final beat accepted
  cfg_err  output  1  one-cycle pulse on start with reserved encoding

Function
REQ-003 Beats per row BPR = max(1, W/16); rows = W; total beats = C*W*BPR; bram_addr runs 0..total-1 in order channel, row, beat.
REQ-004 Pixel i of a beat occupies tdata[16i+15:16i], pixel 0 leftmost; for W=4 or 8, lanes >= W shall be forced to zero.
REQ-005 States: IDLE, RUN, DRAIN; IDLE->RUN on start with legal config; RUN->DRAIN when last address issued; DRAIN->IDLE when final beat handshakes, with done pulsed that cycle+1.
REQ-006 Config is latched on accepted start; input changes during busy have no effect.
REQ-007 start while busy is ignored; start with reserved encoding pulses cfg_err next cycle and stays IDLE.
REQ-008 Latency: start sampled at edge 0 -> bram_en high cycle 1 -> m_axis_tvalid high cycle 2.
REQ-009 Handshake: beat transfers when tvalid&&tready; tdata/tlast held stable while tvalid&&!tready; tvalid never drops without a handshake.
REQ-010 Reads are issued only while (buffer occupancy + in-flight reads) < 2, so no data is lost under arbitrary backpressure.
REQ-011 Sustained throughput is one beat per cycle when tready is held high.
REQ-012 tlast asserted on the last beat of each channel plane (every W*BPR beats), including the final beat.
REQ-013 busy is high from the cycle after accepted start until done pulses; done and busy never both high.

Reset
REQ-014 aresetn low asynchronously clears state to IDLE, bram_en, bram_addr, m_axis_tvalid, m_axis_tlast, busy, done, cfg_err to 0; tdata resets to 0.
REQ-015 Reset mid-transfer drops all buffered and in-flight beats; after release the block waits for a new start.

Configuration
REQ-016 With FM_STREAM_STALL_CNT_EN defined, a 32-bit output stall_cnt counts cycles with tvalid&&!tready, cleared on accepted start and reset, saturating at all-ones; without it the port and counter do not exist.

Structure
REQ-017 Shared package conv_pkg holds image/channel size decode functions, the reserved-encoding check, and LANES/PIXEL_WIDTH constants, used also by the convolution control unit.
REQ-018 The 2-entry output buffer is sub-module fm_stream_skid_fifo (data + tlast, full/empty flags).

Verification
REQ-019 W=4 (choose 0), C=64 (choose 2), tready=1 -> 256 beats, addr 0..255, tlast every 4th beat, tdata[255:64]=0, done after beat 256.
REQ-020 W=128, C=256, tready=1 -> 262144 beats back-to-back, tlast every 1024 beats, addr wraps to 0 only on the next start.
REQ-021 W=16, C=64, random tready at 30% -> beat sequence identical to the BRAM contents, no drop or duplicate, tdata stable during stalls.
REQ-022 start with IMAGE_SIZE_choose=6 -> cfg_err pulse, busy stays 0, no bram_en.
REQ-023 aresetn low at beat 100 of W=32 run, then start -> outputs 0 during reset, new run restarts at addr 0.
REQ-024 With FM_STREAM_STALL_CNT_EN, tready low for exactly 7 cycles mid-run -> stall_cnt=7 at done.
